seg7_scan_driver: RTL and testbench

//   Time-multiplexed driver for DIGITS common-anode/cathode 7-seg digits sharing one segment bus.

---
 rtl/seg7_scan_driver_pkg.sv | 18 +
 rtl/seg7_scan_driver_glyph_rom.sv | 11 +
 rtl/seg7_scan_driver.sv | 138 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_scan_driver_pkg.sv
// Shared 7-segment definitions: segment vector type (gfedcba, active-high) and hex glyph table.
package seg7_pkg;

  typedef logic [6:0] seg7_t;

  // Index = nibble value; bit 6 = g ... bit 0 = a.
  localparam seg7_t SEG7_GLYPHS [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic seg7_t seg7_glyph(input logic [3:0] nibble);
    return SEG7_GLYPHS[nibble];
  endfunction

endpackage

// File: rtl/seg7_scan_driver_glyph_rom.sv
// Combinational hex nibble to active-high gfedcba glyph.
module seg7_glyph_rom
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = seg7_glyph(i_nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scanner: double-buffered hex value, per-slot anti-ghost gap,
// leading-zero suppression, registered pins with configurable polarity.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 2,
  parameter int SEG_ACT_LOW  = 1,
  parameter int AN_ACT_LOW   = 1,
  parameter int LZ_SUPPRESS  = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_load,
  input  logic [4*DIGITS-1:0]   i_value,
  input  logic [DIGITS-1:0]     i_dp_in,
  input  logic [DIGITS-1:0]     i_blank_in,
  output logic [6:0]            o_seg,
  output logic                  o_dp,
  output logic [DIGITS-1:0]     o_an,
  output logic                  o_frame
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  // XOR masks equal to the unlit level of each pin group.
  localparam logic [6:0]        SEG_OFF = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic              DP_OFF  = (SEG_ACT_LOW != 0);
  localparam logic [DIGITS-1:0] AN_OFF  = (AN_ACT_LOW != 0) ? {DIGITS{1'b1}} : '0;

  logic [PW-1:0]         r_presc;
  logic [IW-1:0]         r_idx;
  logic [4*DIGITS-1:0]   r_pend_val;
  logic [DIGITS-1:0]     r_pend_dp;
  logic [DIGITS-1:0]     r_pend_blk;
  logic                  r_pend_valid;
  logic [4*DIGITS-1:0]   r_act_val;
  logic [DIGITS-1:0]     r_act_dp;
  logic [DIGITS-1:0]     r_act_blk;
  logic [6:0]            r_seg;
  logic                  r_dp;
  logic [DIGITS-1:0]     r_an;

  logic                  w_presc_tc;
  logic                  w_idx_last;
  logic                  w_frame;
  logic                  w_in_gap;
  logic [3:0]            w_nibble;
  logic [6:0]            w_glyph;
  logic [DIGITS-1:0]     w_lz_dark;
  logic                  w_dark;
  logic [6:0]            w_seg_hi;
  logic                  w_dp_hi;
  logic [DIGITS-1:0]     w_an_hi;

  assign w_presc_tc = (r_presc == PW'(REFRESH_DIV - 1));
  assign w_idx_last = (r_idx == IW'(DIGITS - 1));
  assign w_frame    = w_presc_tc && w_idx_last;
  assign o_frame    = w_frame;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (w_presc_tc) begin
      r_presc <= '0;
      r_idx   <= w_idx_last ? '0 : r_idx + IW'(1);
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  // Active buffer only changes on the frame boundary so a scan never mixes two values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pend_val   <= '0;
      r_pend_dp    <= '0;
      r_pend_blk   <= '0;
      r_pend_valid <= 1'b0;
      r_act_val    <= '0;
      r_act_dp     <= '0;
      r_act_blk    <= '0;
    end else begin
      if (w_frame && r_pend_valid) begin
        r_act_val <= r_pend_val;
        r_act_dp  <= r_pend_dp;
        r_act_blk <= r_pend_blk;
      end
      if (i_load) begin
        r_pend_val   <= i_value;
        r_pend_dp    <= i_dp_in;
        r_pend_blk   <= i_blank_in;
        r_pend_valid <= 1'b1;
      end else if (w_frame) begin
        r_pend_valid <= 1'b0;
      end
    end
  end

  assign w_nibble = r_act_val[{r_idx, 2'b00} +: 4];

  seg7_glyph_rom u_glyph_rom (
    .i_nibble (w_nibble),
    .o_seg    (w_glyph)
  );

  always_comb begin
    w_lz_dark = '0;
    for (int k = 1; k < DIGITS; k++) begin
      w_lz_dark[k] = (LZ_SUPPRESS != 0) && ((r_act_val >> (4 * k)) == '0);
    end
  end

  assign w_in_gap = (int'(r_presc) < BLANK_CYCLES);
  assign w_dark   = r_act_blk[r_idx] || w_lz_dark[r_idx];
  assign w_seg_hi = (w_in_gap || w_dark) ? 7'h00 : w_glyph;
  assign w_dp_hi  = !w_in_gap && !r_act_blk[r_idx] && r_act_dp[r_idx];
  assign w_an_hi  = w_in_gap ? '0 : (DIGITS'(1) << r_idx);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_seg <= SEG_OFF;
      r_dp  <= DP_OFF;
      r_an  <= AN_OFF;
    end else begin
      r_seg <= w_seg_hi ^ SEG_OFF;
      r_dp  <= w_dp_hi ^ DP_OFF;
      r_an  <= w_an_hi ^ AN_OFF;
    end
  end

  assign o_seg = r_seg;
  assign o_dp  = r_dp;
  assign o_an  = r_an;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: cycle-count reference model checked every cycle, plus literal frame captures.
module tb_seg7_scan_driver;

  localparam int D     = 4;
  localparam int DIV   = 4;
  localparam int BLANK = 1;
  localparam int FRAME_LEN = D * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_load = 1'b0;
  logic [15:0] i_value = '0;
  logic [3:0]  i_dp_in = '0;
  logic [3:0]  i_blank_in = '0;
  logic [6:0]  o_seg;
  logic        o_dp;
  logic [3:0]  o_an;
  logic        o_frame;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  seg7_scan_driver #(
    .DIGITS(D), .REFRESH_DIV(DIV), .BLANK_CYCLES(BLANK),
    .SEG_ACT_LOW(1), .AN_ACT_LOW(1), .LZ_SUPPRESS(1)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_load(i_load), .i_value(i_value),
    .i_dp_in(i_dp_in), .i_blank_in(i_blank_in),
    .o_seg(o_seg), .o_dp(o_dp), .o_an(o_an), .o_frame(o_frame)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  // ---------------- reference model ----------------
  string glyph_str [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                            "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  function automatic logic [6:0] glyph(input int n);
    string s;
    logic [6:0] g;
    s = glyph_str[n];
    g = '0;
    for (int i = 0; i < s.len(); i++) g[int'(s[i]) - 97] = 1'b1;
    return g;
  endfunction

  int          m_cnt;
  logic [15:0] m_pend_val, m_act_val;
  logic [3:0]  m_pend_dp, m_act_dp, m_pend_blk, m_act_blk;
  logic        m_pv;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt = 0; m_pv = 0;
      m_pend_val = '0; m_pend_dp = '0; m_pend_blk = '0;
      m_act_val = '0; m_act_dp = '0; m_act_blk = '0;
      exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
    end else begin
      int p, idx;
      logic dark;
      logic [3:0] an_hi;
      logic [6:0] seg_hi;
      logic dp_hi;
      p   = m_cnt % DIV;
      idx = (m_cnt / DIV) % D;
      an_hi = '0; seg_hi = '0; dp_hi = 1'b0;
      if (p >= BLANK) begin
        an_hi  = 4'(1 << idx);
        dark   = m_act_blk[idx] || (idx > 0 && (m_act_val >> (4 * idx)) == 0);
        seg_hi = dark ? 7'h00 : glyph(int'((m_act_val >> (4 * idx)) & 16'hF));
        dp_hi  = m_act_dp[idx] && !m_act_blk[idx];
      end
      exp_an = ~an_hi; exp_seg = ~seg_hi; exp_dp = ~dp_hi;
      if ((m_cnt % FRAME_LEN) == FRAME_LEN - 1 && m_pv) begin
        m_act_val = m_pend_val; m_act_dp = m_pend_dp; m_act_blk = m_pend_blk;
        m_pv = 0;
      end
      if (i_load) begin
        m_pend_val = i_value; m_pend_dp = i_dp_in; m_pend_blk = i_blank_in;
        m_pv = 1;
      end
      m_cnt++;
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (!rst) begin
      chk("model_an", o_an, exp_an);
      chk("model_seg", o_seg, exp_seg);
      chk("model_dp", o_dp, exp_dp);
      chk("model_frame", o_frame, ((m_cnt % FRAME_LEN) == FRAME_LEN - 1));
    end
  end

  // ---------------- driver tasks ----------------
  logic [3:0] cap_gap [4];
  logic [3:0] cap_an  [4];
  logic [6:0] cap_seg [4];
  logic       cap_dp  [4];
  int         frame_cyc;

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] blk);
    @(negedge clk);
    i_value = v; i_dp_in = dp; i_blank_in = blk; i_load = 1'b1;
    @(negedge clk);
    i_load = 1'b0;
  endtask

  task automatic wait_frame();
    for (int k = 0; k < 3 * FRAME_LEN; k++) begin
      @(negedge clk);
      if (o_frame) break;
    end
    chk("frame_seen", o_frame, 1'b1);
    frame_cyc = cyc;
  endtask

  // Called at the negedge of a FRAME cycle; records the gap and lit phase of each slot of the next frame.
  task automatic capture_frame();
    for (int j = 1; j <= FRAME_LEN; j++) begin
      @(posedge clk);
      #1;
      if (j == 1) i_load = 1'b0;
      for (int k = 0; k < D; k++) begin
        if (j == 2 + DIV * k) cap_gap[k] = o_an;
        if (j == 3 + DIV * k) begin
          cap_an[k] = o_an; cap_seg[k] = o_seg; cap_dp[k] = o_dp;
        end
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t0;
    repeat (3) @(negedge clk);
    chk("reset_an", o_an, 4'hF);
    chk("reset_seg", o_seg, 7'h7F);
    chk("reset_dp", o_dp, 1'b1);
    chk("reset_frame", o_frame, 1'b0);
    rst = 1'b0;

    do_load(16'h1234, 4'h0, 4'h0);
    wait_frame();
    capture_frame();
    chk("h1234_d0_gap_an", cap_gap[0], 4'b1111);
    chk("h1234_d0_an", cap_an[0], 4'b1110);
    chk("h1234_d0_seg", cap_seg[0], 7'b0011001);
    chk("h1234_d3_seg", cap_seg[3], 7'b1111001);

    repeat (3) @(negedge clk);
    do_load(16'h0050, 4'h0, 4'h0);
    wait_frame();
    capture_frame();
    chk("h0050_d3_an", cap_an[3], 4'b0111);
    chk("h0050_d3_seg", cap_seg[3], 7'b1111111);
    chk("h0050_d2_an", cap_an[2], 4'b1011);
    chk("h0050_d2_seg", cap_seg[2], 7'b1111111);
    chk("h0050_d1_seg", cap_seg[1], 7'b0010010);
    chk("h0050_d0_seg", cap_seg[0], 7'b1000000);

    repeat (3) @(negedge clk);
    do_load(16'h0000, 4'b0100, 4'h0);
    wait_frame();
    capture_frame();
    chk("h0000_d2_seg", cap_seg[2], 7'b1111111);
    chk("h0000_d2_dp", cap_dp[2], 1'b0);
    chk("h0000_d1_dp", cap_dp[1], 1'b1);
    chk("h0000_d0_seg", cap_seg[0], 7'b1000000);

    wait_frame();
    repeat (3) @(negedge clk);
    do_load(16'hABCD, 4'h0, 4'h0);
    repeat (4) @(negedge clk);
    do_load(16'hEF01, 4'h0, 4'h0);
    wait_frame();
    capture_frame();
    chk("last_load_d3", cap_seg[3], 7'b0000110);
    chk("last_load_d2", cap_seg[2], 7'b0001110);
    chk("last_load_d1", cap_seg[1], 7'b1000000);
    chk("last_load_d0", cap_seg[0], 7'b1111001);

    wait_frame();
    t0 = frame_cyc;
    i_value = 16'h8888; i_dp_in = 4'h0; i_blank_in = 4'h0; i_load = 1'b1;
    capture_frame();
    chk("load_on_frame_old_d0", cap_seg[0], 7'b1111001);
    wait_frame();
    chk("frame_period", frame_cyc - t0, FRAME_LEN);
    capture_frame();
    chk("load_on_frame_new_d3", cap_seg[3], 7'b0000000);
    chk("load_on_frame_new_d0", cap_seg[0], 7'b0000000);

    repeat (2) @(negedge clk);
    do_load(16'h4321, 4'h0, 4'h0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midslot_rst_an", o_an, 4'hF);
    chk("midslot_rst_seg", o_seg, 7'h7F);
    chk("midslot_rst_frame", o_frame, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    wait_frame();
    capture_frame();
    chk("post_rst_d0", cap_seg[0], 7'b1000000);
    chk("post_rst_d1", cap_seg[1], 7'b1111111);

    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) begin
        i_value    = 16'($urandom) >> $urandom_range(0, 16);
        i_dp_in    = 4'($urandom);
        i_blank_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
        i_load     = 1'b1;
      end else begin
        i_load = 1'b0;
      end
    end
    i_load = 1'b0;
    repeat (2 * FRAME_LEN) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
